bus_slave: RTL and testbench



---
 rtl/bus_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_bus_slave.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave.sv
// bus_slave: responder on the single-wire serial bus.
// Deserialises a 16-bit address (LSB first), decodes the device select,
// acknowledges a match, then either captures a write byte (LSB first) into
// local memory or serialises a read byte (MSB first) back to the master.
//
// Bus handshake: a bit is transferred on every rising CLK edge where its
// qualifier is high (S_UTIL for master->slave bits, S_UTIL_OUT for
// slave->master bits). Acknowledge is a window of ACK_LEN cycles with S_ACK
// high; the master samples it on the last cycle of the window. All slave
// outputs are decoded from registered state, so they never depend
// combinationally on bus inputs. dbg_state mirrors the FSM state.
module bus_slave #(
    parameter logic [3:0] DEV_ID  = 4'h1,
    parameter int         MEM_AW  = 8,
    parameter int         ACK_LEN = 4
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       S_BUS_IN,
    input  logic       S_UTIL,
    input  logic       S_RW,
    input  logic       S_BUS_ACK,
    output logic       S_ACK,
    output logic       S_BUS_OUT,
    output logic       S_UTIL_OUT,
    output logic       S_BSY,
    output logic       S_WR_STB,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_A  = 3'd2,
        WDATA  = 3'd3,
        ACK_W  = 3'd4,
        RDATA  = 3'd5,
        SKIP_A = 3'd6,
        SKIP_D = 3'd7
    } state_t;

    localparam int CW    = 8;
    localparam int DEPTH = 1 << MEM_AW;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [15:0]       addr;
    logic              rw;
    logic              ack_seen;
    logic [7:0]        shreg;
    logic [7:0]        mem [0:DEPTH-1];
    logic [MEM_AW-1:0] idx;
    logic              sel;
    logic              ack_last;
    logic              commit;
    logic [CW-1:0]     skip_len;

    assign idx      = addr[MEM_AW-1:0];
    // Bits 14:12 are already held; bit 15 is arriving on the bus this cycle.
    assign sel      = ({S_BUS_IN, addr[14:12]} == DEV_ID);
    assign ack_last = (cnt == CW'(ACK_LEN - 1));
    // A foreign write still has its 8 data bits and an ACK window to run;
    // a foreign read only has its 8 data bits.
    assign skip_len = rw ? CW'(8 + ACK_LEN - 1) : CW'(7);

    assign S_BSY     = (state != IDLE);
    assign dbg_state = state;

    // Address bits above the memory index take no part in decode.
    if (MEM_AW < 12) begin : g_unused_addr
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[11:MEM_AW];
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, bit counter and Moore bus outputs.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        commit     = 1'b0;
        S_ACK      = 1'b0;
        S_BUS_OUT  = 1'b0;
        S_UTIL_OUT = 1'b0;
        unique case (state)
            IDLE: begin
                if (S_UTIL) begin
                    state_nxt = ADDR;
                    cnt_nxt   = CW'(1);
                end
            end
            ADDR: begin
                if (!S_UTIL) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(15)) begin
                    state_nxt = sel ? ACK_A : SKIP_A;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ACK_A: begin
                S_ACK = 1'b1;
                if (ack_last) begin
                    state_nxt = rw ? WDATA : RDATA;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WDATA: begin
                if (S_UTIL) begin
                    if (cnt == CW'(7)) begin
                        commit    = 1'b1;
                        state_nxt = ACK_W;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            ACK_W: begin
                S_ACK = 1'b1;
                if (ack_last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RDATA: begin
                S_UTIL_OUT = 1'b1;
                S_BUS_OUT  = shreg[7];
                if (cnt == CW'(7)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SKIP_A: begin
                if (ack_last) begin
                    state_nxt = (ack_seen || S_BUS_ACK) ? SKIP_D : IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SKIP_D: begin
                if (cnt == skip_len) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Datapath: address capture, data shift register, foreign-ACK tracking, write strobe.
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            addr     <= '0;
            rw       <= 1'b0;
            ack_seen <= 1'b0;
            shreg    <= '0;
            S_WR_STB <= 1'b0;
        end else begin
            S_WR_STB <= commit;
            unique case (state)
                IDLE: begin
                    if (S_UTIL) begin
                        addr <= {15'h0000, S_BUS_IN};
                        rw   <= S_RW;
                    end
                end
                ADDR: begin
                    ack_seen <= 1'b0;
                    if (S_UTIL) begin
                        addr[cnt[3:0]] <= S_BUS_IN;
                    end
                end
                ACK_A: begin
                    if (ack_last && !rw) begin
                        shreg <= mem[idx];
                    end
                end
                WDATA: begin
                    if (S_UTIL) begin
                        shreg <= {S_BUS_IN, shreg[7:1]};
                    end
                end
                RDATA: begin
                    shreg <= {shreg[6:0], 1'b0};
                end
                SKIP_A: begin
                    if (S_BUS_ACK) begin
                        ack_seen <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Local byte memory; cleared on reset, written when the 8th data bit lands.
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (commit) begin
            mem[idx] <= {S_BUS_IN, shreg[7:1]};
        end
    end

endmodule

// File: tb/tb_bus_slave.sv
// tb_bus_slave: scenario tasks driving the serial bus into bus_slave, with a
// byte-level reference memory and a queue of expected read bytes.
module tb_bus_slave;

    localparam logic [3:0] DEV_ID  = 4'h1;
    localparam int         MEM_AW  = 8;
    localparam int         ACK_LEN = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WDATA = 3'd3;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       S_BUS_IN;
    logic       S_UTIL;
    logic       S_RW;
    logic       S_BUS_ACK;
    logic       S_ACK;
    logic       S_BUS_OUT;
    logic       S_UTIL_OUT;
    logic       S_BSY;
    logic       S_WR_STB;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] model_mem [0:255];
    logic [7:0] exp_q[$];

    // Clock
    always #5 CLK = ~CLK;

    bus_slave #(
        .DEV_ID  (DEV_ID),
        .MEM_AW  (MEM_AW),
        .ACK_LEN (ACK_LEN)
    ) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .S_BUS_IN   (S_BUS_IN),
        .S_UTIL     (S_UTIL),
        .S_RW       (S_RW),
        .S_BUS_ACK  (S_BUS_ACK),
        .S_ACK      (S_ACK),
        .S_BUS_OUT  (S_BUS_OUT),
        .S_UTIL_OUT (S_UTIL_OUT),
        .S_BSY      (S_BSY),
        .S_WR_STB   (S_WR_STB),
        .dbg_state  (dbg_state)
    );

    // Inputs set before a tick are consumed at that edge; outputs read after
    // a tick belong to the following cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        S_UTIL    = 1'b0;
        S_BUS_IN  = 1'b0;
        S_RW      = 1'b0;
        S_BUS_ACK = 1'b0;
    endtask

    // RW is presented with the first bit only; it is inverted afterwards.
    task automatic send_addr(input logic [15:0] a, input logic rw);
        for (int i = 0; i < 16; i++) begin
            S_UTIL   = 1'b1;
            S_BUS_IN = a[i];
            S_RW     = (i == 0) ? rw : ~rw;
            tick();
        end
        idle_inputs();
    endtask

    // Full write transaction; gap_at inserts one S_UTIL=0 cycle before that data bit.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int gap_at);
        int acks;
        int outs;
        int stb_early;
        int stb_late;
        send_addr(a, 1'b1);
        acks = 0;
        outs = 0;
        for (int k = 0; k < ACK_LEN; k++) begin
            if (S_ACK === 1'b1) acks++;
            if (S_UTIL_OUT !== 1'b0) outs++;
            tick();
        end
        n_checks++;
        if (acks != ACK_LEN || outs != 0 || dbg_state !== ST_WDATA || S_ACK !== 1'b0)
            $display("FAIL wr_addr_ack %h: ack=%0d util_out=%0d state=%0d, required ack=%0d util_out=0 state=%0d",
                     a, acks, outs, dbg_state, ACK_LEN, ST_WDATA);
        else n_pass++;
        stb_early = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                S_UTIL   = 1'b0;
                S_BUS_IN = ~d[i];
                if (S_WR_STB !== 1'b0) stb_early++;
                tick();
            end
            S_UTIL   = 1'b1;
            S_BUS_IN = d[i];
            if (S_WR_STB !== 1'b0) stb_early++;
            tick();
        end
        idle_inputs();
        n_checks++;
        if (S_WR_STB !== 1'b1 || stb_early != 0)
            $display("FAIL wr_stb_commit %h: stb=%b early_stb=%0d, required stb=1 early_stb=0",
                     a, S_WR_STB, stb_early);
        else n_pass++;
        acks     = 0;
        stb_late = 0;
        for (int k = 0; k < ACK_LEN; k++) begin
            if (S_ACK === 1'b1) acks++;
            if (S_WR_STB === 1'b1) stb_late++;
            tick();
        end
        n_checks++;
        if (acks != ACK_LEN || stb_late != 1 || dbg_state !== ST_IDLE || S_BSY !== 1'b0)
            $display("FAIL wr_data_ack %h: ack=%0d stb=%0d state=%0d bsy=%b, required ack=%0d stb=1 state=0 bsy=0",
                     a, acks, stb_late, dbg_state, S_BSY, ACK_LEN);
        else n_pass++;
        model_mem[a[7:0]] = d;
    endtask

    // Full read transaction; the expected byte is queued when the address goes out.
    task automatic do_read(input logic [15:0] a);
        int         acks;
        int         outs;
        int         bad_ack;
        logic [7:0] got;
        logic [7:0] exp;
        exp_q.push_back(model_mem[a[7:0]]);
        send_addr(a, 1'b0);
        acks = 0;
        outs = 0;
        for (int k = 0; k < ACK_LEN; k++) begin
            if (S_ACK === 1'b1) acks++;
            if (S_UTIL_OUT !== 1'b0) outs++;
            tick();
        end
        n_checks++;
        if (acks != ACK_LEN || outs != 0)
            $display("FAIL rd_addr_ack %h: ack=%0d util_out=%0d, required ack=%0d util_out=0",
                     a, acks, outs, ACK_LEN);
        else n_pass++;
        got     = 8'h00;
        outs    = 0;
        bad_ack = 0;
        for (int i = 0; i < 8; i++) begin
            if (S_UTIL_OUT === 1'b1) outs++;
            if (S_ACK !== 1'b0) bad_ack++;
            got = {got[6:0], S_BUS_OUT};
            tick();
        end
        n_checks++;
        if (outs != 8 || bad_ack != 0 || S_UTIL_OUT !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL rd_frame %h: util_out=%0d ack_during=%0d end_util_out=%b state=%0d, required 8 0 0 0",
                     a, outs, bad_ack, S_UTIL_OUT, dbg_state);
        else n_pass++;
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp)
            $display("FAIL rd_data %h: got %h, required %h", a, got, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        RSTN = 1'b1;
        idle_inputs();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        tick();
        tick();
        n_checks++;
        if ({S_ACK, S_BUS_OUT, S_UTIL_OUT, S_BSY, S_WR_STB} !== 5'b0 || dbg_state !== ST_IDLE)
            $display("FAIL reset_outputs: outs=%b state=%0d, required 00000 state=0",
                     {S_ACK, S_BUS_OUT, S_UTIL_OUT, S_BSY, S_WR_STB}, dbg_state);
        else n_pass++;
        RSTN = 1'b0;
        tick();
        tick();
        n_checks++;
        if (S_BSY !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL reset_release: bsy=%b state=%0d, required 0 0", S_BSY, dbg_state);
        else n_pass++;
    endtask

    task automatic test_write_hit();
        do_write(16'h1034, 8'hA5, 3);
    endtask

    task automatic test_read_hit();
        do_read(16'h1034);
    endtask

    task automatic test_miss_quiet();
        int acks;
        send_addr(16'h2034, 1'b1);
        acks = 0;
        for (int k = 0; k < ACK_LEN; k++) begin
            if (S_ACK !== 1'b0) acks++;
            tick();
        end
        n_checks++;
        if (acks != 0 || dbg_state !== ST_IDLE || S_BSY !== 1'b0)
            $display("FAIL miss_quiet: ack=%0d state=%0d bsy=%b, required 0 0 0", acks, dbg_state, S_BSY);
        else n_pass++;
        do_read(16'h1034);
    endtask

    task automatic test_miss_busy();
        logic [15:0] a;
        int          acks;
        int          stbs;
        int          free_at;
        int          frame_len;
        a         = 16'h2034;
        frame_len = 16 + ACK_LEN + 8 + ACK_LEN;
        acks      = 0;
        stbs      = 0;
        free_at   = -1;
        for (int c = 0; c < frame_len + 4; c++) begin
            idle_inputs();
            if (c < 16) begin
                S_UTIL   = 1'b1;
                S_BUS_IN = a[c];
                S_RW     = (c == 0) ? 1'b1 : 1'b0;
            end else if (c < 16 + ACK_LEN) begin
                S_BUS_ACK = (c == 17);
            end else if (c < 24 + ACK_LEN) begin
                S_UTIL   = 1'b1;
                S_BUS_IN = 1'b1;
            end else if (c < frame_len) begin
                S_BUS_ACK = 1'b1;
            end
            tick();
            if (S_ACK !== 1'b0) acks++;
            if (S_WR_STB !== 1'b0) stbs++;
            if (free_at < 0 && S_BSY === 1'b0) free_at = c + 1;
        end
        idle_inputs();
        n_checks++;
        if (acks != 0 || stbs != 0)
            $display("FAIL miss_busy_quiet: ack=%0d stb=%0d, required 0 0", acks, stbs);
        else n_pass++;
        n_checks++;
        if (free_at != frame_len)
            $display("FAIL miss_busy_len: idle at cycle %0d, required %0d", free_at, frame_len);
        else n_pass++;
        do_read(16'h1034);
    endtask

    task automatic test_abort();
        logic [15:0] a;
        a = 16'h1034;
        for (int i = 0; i < 10; i++) begin
            S_UTIL   = 1'b1;
            S_BUS_IN = a[i];
            S_RW     = 1'b1;
            tick();
        end
        idle_inputs();
        tick();
        n_checks++;
        if (dbg_state !== ST_IDLE || S_ACK !== 1'b0 || S_BSY !== 1'b0)
            $display("FAIL abort_idle: state=%0d ack=%b bsy=%b, required 0 0 0", dbg_state, S_ACK, S_BSY);
        else n_pass++;
        do_write(16'h1001, 8'h3C, -1);
        do_read(16'h1001);
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] a;
        logic [7:0]  d;
        int          stbs;
        a = 16'h1055;
        d = 8'h5A;
        send_addr(a, 1'b1);
        for (int k = 0; k < ACK_LEN; k++) tick();
        for (int i = 0; i < 4; i++) begin
            S_UTIL   = 1'b1;
            S_BUS_IN = d[i];
            tick();
        end
        S_BUS_IN = d[4];
        RSTN     = 1'b1;
        #1;
        n_checks++;
        if ({S_ACK, S_BUS_OUT, S_UTIL_OUT, S_BSY, S_WR_STB} !== 5'b0 || dbg_state !== ST_IDLE)
            $display("FAIL reset_mid_outputs: outs=%b state=%0d, required 00000 state=0",
                     {S_ACK, S_BUS_OUT, S_UTIL_OUT, S_BSY, S_WR_STB}, dbg_state);
        else n_pass++;
        stbs = 0;
        for (int i = 5; i < 8; i++) begin
            S_BUS_IN = d[i];
            tick();
            if (S_WR_STB !== 1'b0) stbs++;
        end
        idle_inputs();
        RSTN = 1'b0;
        tick();
        n_checks++;
        if (stbs != 0 || S_WR_STB !== 1'b0)
            $display("FAIL reset_mid_stb: stb=%0d, required 0", stbs);
        else n_pass++;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        do_read(a);
        do_read(16'h1034);
        do_read(16'h1001);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  idx;
        logic [3:0]  hi;
        logic [7:0]  d;
        logic [15:0] a;
        for (int n = 0; n < 6; n++) begin
            idx = 8'($urandom_range(0, 255));
            hi  = 4'($urandom_range(0, 15));
            d   = 8'($urandom_range(0, 255));
            a   = {DEV_ID, hi, idx};
            do_write(a, d, int'($urandom_range(0, 8)));
            do_read({DEV_ID, ~hi, idx});
        end
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_hit();
        test_read_hit();
        test_miss_quiet();
        test_miss_busy();
        test_abort();
        test_reset_mid_write();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
